// File: rtl/pll_reset_sequencer_if.sv
// Lock-flag inputs and staged reset outputs of the PLL reset sequencer.
interface pll_reset_sequencer_if #(
  parameter int NUM_PLLS   = 2,
  parameter int NUM_STAGES = 3
);
  logic [NUM_PLLS-1:0]   pll_lock;
  logic                  sw_reset_req;
  logic [NUM_STAGES-1:0] rst_out_n;
  logic                  all_ready;
  logic [15:0]           lock_lost_count;
  logic [1:0]            state_dbg;

  modport master (
    output pll_lock, sw_reset_req,
    input  rst_out_n, all_ready, lock_lost_count, state_dbg
  );

  modport slave (
    input  pll_lock, sw_reset_req,
    output rst_out_n, all_ready, lock_lost_count, state_dbg
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock for a stable window, then releases active-low resets in
// index order; any lock loss or software request reasserts every stage.
module pll_reset_sequencer #(
  parameter int NUM_PLLS           = 2,
  parameter int NUM_STAGES         = 3,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_DELAY        = 16,
  parameter int SYNC_STAGES        = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  pll_reset_sequencer_if.slave bus
);

  localparam int MAX_CNT = (LOCK_STABLE_CYCLES > STAGE_DELAY) ? LOCK_STABLE_CYCLES : STAGE_DELAY;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int SW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [SW-1:0]                 stage_q, stage_d;
  logic [NUM_STAGES-1:0]         rst_q, rst_d;
  logic                          ready_q, ready_d;
  logic [15:0]                   loss_q, loss_d;
  logic [SYNC_STAGES-1:0][NUM_PLLS-1:0] sync_q;
  logic                          lock_ok;
  logic                          abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_lock};
    end
  end

  assign lock_ok = &sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      stage_q <= '0;
      rst_q   <= '0;
      ready_q <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      loss_q  <= loss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    rst_d   = rst_q;
    loss_d  = loss_q;
    abort   = (state_q != WAIT_LOCK) && (!lock_ok || bus.sw_reset_req);

    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d   = '0;
        stage_d = '0;
        rst_d   = '0;
        if (lock_ok) state_d = STABLE;
      end
      STABLE: begin
        if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (cnt_q == CW'(STAGE_DELAY - 1)) begin
          rst_d[stage_q] = 1'b1;
          cnt_d          = '0;
          if (stage_q == SW'(NUM_STAGES - 1)) state_d = RUN;
          else                                stage_d = stage_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: ;
      default: state_d = WAIT_LOCK;
    endcase

    // Abort overrides any progress made this cycle; a concurrent software
    // request does not add a second loss event.
    if (abort) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      stage_d = '0;
      rst_d   = '0;
      if (!lock_ok && loss_q != '1) loss_d = loss_q + 1'b1;
    end

    // Registered one cycle behind RUN entry, and dropped on the abort edge.
    ready_d = (state_q == RUN) && (state_d == RUN);
  end

  assign bus.rst_out_n       = rst_q;
  assign bus.all_ready       = ready_q;
  assign bus.lock_lost_count = loss_q;
  assign bus.state_dbg       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer at default parameters.
module tb_pll_reset_sequencer;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic [15:0] exp_loss;

  pll_reset_sequencer_if #(.NUM_PLLS(2), .NUM_STAGES(3)) bus ();

  pll_reset_sequencer #(
    .NUM_PLLS(2),
    .NUM_STAGES(3),
    .LOCK_STABLE_CYCLES(1024),
    .STAGE_DELAY(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [2:0] r, input logic rdy,
                             input logic [1:0] st);
    chk({tag, ".rst"},   32'(bus.rst_out_n), 32'(r));
    chk({tag, ".ready"}, 32'(bus.all_ready), 32'(rdy));
    chk({tag, ".state"}, 32'(bus.state_dbg), 32'(st));
  endtask

  // base = edges from the current point to the start of cycle L.
  task automatic check_sequence(input string tag, input int base);
    ticks(base + 1040);
    chk_outputs({tag, ".pre0"}, 3'b000, 1'b0, 2'd2);
    tick();
    chk_outputs({tag, ".rel0"}, 3'b001, 1'b0, 2'd2);
    ticks(15);
    chk({tag, ".pre1"}, 32'(bus.rst_out_n), 32'h1);
    tick();
    chk({tag, ".rel1"}, 32'(bus.rst_out_n), 32'h3);
    ticks(15);
    chk({tag, ".pre2"}, 32'(bus.rst_out_n), 32'h3);
    tick();
    chk_outputs({tag, ".rel2"}, 3'b111, 1'b0, 2'd3);
    tick();
    chk_outputs({tag, ".run"}, 3'b111, 1'b1, 2'd3);
    chk({tag, ".loss"}, 32'(bus.lock_lost_count), 32'(exp_loss));
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    exp_loss         = 16'd0;
    rst_n            = 1'b0;
    bus.pll_lock     = 2'b11;
    bus.sw_reset_req = 1'b0;

    ticks(2);
    chk_outputs("reset", 3'b000, 1'b0, 2'd0);
    chk("reset.loss", 32'(bus.lock_lost_count), 32'h0);

    // 1: power-up sequence with locks already high
    rst_n = 1'b1;
    check_sequence("t1", 2);

    // 2: pll_lock[1] drops for 20 cycles in RUN
    bus.pll_lock = 2'b01;
    ticks(3);
    exp_loss = 16'd1;
    chk_outputs("t2.abort", 3'b000, 1'b0, 2'd0);
    chk("t2.loss", 32'(bus.lock_lost_count), 32'(exp_loss));
    ticks(17);
    chk_outputs("t2.held", 3'b000, 1'b0, 2'd0);
    bus.pll_lock = 2'b11;
    check_sequence("t2", 2);

    // 3: lock drops at STABLE cnt=500
    bus.pll_lock = 2'b00;
    ticks(3);
    exp_loss = 16'd2;
    chk("t3.loss_a", 32'(bus.lock_lost_count), 32'(exp_loss));
    ticks(7);
    bus.pll_lock = 2'b11;
    ticks(503);
    chk_outputs("t3.stable", 3'b000, 1'b0, 2'd1);
    bus.pll_lock = 2'b10;
    ticks(3);
    exp_loss = 16'd3;
    chk_outputs("t3.abort", 3'b000, 1'b0, 2'd0);
    chk("t3.loss_b", 32'(bus.lock_lost_count), 32'(exp_loss));
    ticks(5);
    bus.pll_lock = 2'b11;
    check_sequence("t3", 2);

    // 4: software reset pulse in RUN
    bus.sw_reset_req = 1'b1;
    tick();
    bus.sw_reset_req = 1'b0;
    chk_outputs("t4.abort", 3'b000, 1'b0, 2'd0);
    chk("t4.loss", 32'(bus.lock_lost_count), 32'(exp_loss));
    check_sequence("t4", 0);

    // 5: saturation of the loss counter
    bus.pll_lock = 2'b00;
    ticks(3);
    exp_loss = 16'd4;
    chk("t5.loss_pre", 32'(bus.lock_lost_count), 32'(exp_loss));
    ticks(2);
    force dut.loss_q = 16'hFFFE;
    #1;
    release dut.loss_q;
    exp_loss = 16'hFFFE;
    tick();
    chk("t5.preload", 32'(bus.lock_lost_count), 32'(exp_loss));
    for (int n = 0; n < 3; n++) begin
      bus.pll_lock = 2'b11;
      ticks(3);
      chk("t5.stable", 32'(bus.state_dbg), 32'd1);
      bus.pll_lock = 2'b00;
      ticks(3);
      exp_loss = 16'hFFFF;
      chk("t5.sat", 32'(bus.lock_lost_count), 32'(exp_loss));
      ticks(2);
    end

    // 6: async reset mid-RELEASE
    bus.pll_lock = 2'b11;
    ticks(1050);
    chk_outputs("t6.mid", 3'b001, 1'b0, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    exp_loss = 16'd0;
    chk_outputs("t6.async", 3'b000, 1'b0, 2'd0);
    chk("t6.loss", 32'(bus.lock_lost_count), 32'(exp_loss));
    tick();
    rst_n = 1'b1;
    check_sequence("t6", 2);

    // sw_reset_req in WAIT_LOCK is ignored
    bus.pll_lock = 2'b00;
    ticks(4);
    bus.sw_reset_req = 1'b1;
    tick();
    bus.sw_reset_req = 1'b0;
    chk_outputs("t7.idle", 3'b000, 1'b0, 2'd0);
    chk("t7.loss", 32'(bus.lock_lost_count), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
